// File: rtl/tt_schedule_sequencer.sv
// rtl/tt_schedule_sequencer.sv - time-triggered schedule table sequencer with global time base
module tt_schedule_sequencer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [28:0]      cycle_len,
  input  logic [IDX_W:0]   num_entries,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             tx_in,
  output logic [31:0]      GTB,
  output logic [31:0]      schedule,
  output logic [IDX_W-1:0] index,
  output logic             running,
  output logic             cycle_done,
  output logic             miss,
  output logic             wr_err
);

  localparam logic [31:0]    PARK    = 32'h1FFF_FFFF;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [28:0]     gtb_q, gtb_d;
  logic [28:0]     len_q, len_d;
  // Index is one bit wider than the table address so it can sit at count == DEPTH (parked).
  logic [IDX_W:0]  idx_q, idx_d;
  logic [IDX_W:0]  cnt_q, cnt_d;
  logic [31:0]     sched_q, sched_d;
  // Set for the cycle after any index change: sched_q still reflects the previous entry then.
  logic            blank_q, blank_d;
  logic            cycle_done_q, cycle_done_d;
  logic            miss_q, miss_d;
  logic            wr_err_q, wr_err_d;
  logic [31:0]     tbl_q [DEPTH];

  logic            wrap;
  logic            in_range;
  logic            late;

  assign wrap     = (gtb_q == (len_q - 29'd1));
  assign in_range = (idx_q < cnt_q);
  assign late     = ({1'b0, gtb_q} > ({1'b0, sched_q[28:0]} + 30'd1));

  // Next-state and datapath logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d      = state_q;
    gtb_d        = gtb_q;
    len_d        = len_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    sched_d      = sched_q;
    blank_d      = blank_q;
    cycle_done_d = 1'b0;
    miss_d       = 1'b0;
    wr_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        gtb_d   = '0;
        idx_d   = '0;
        sched_d = PARK;
        blank_d = 1'b1;
        if (enable) begin
          state_d = RUN;
          len_d   = (cycle_len < 29'd2) ? 29'd2 : cycle_len;
          cnt_d   = (num_entries > DEPTH_C) ? DEPTH_C : num_entries;
        end
      end
      RUN: begin
        wr_err_d = wr_en;
        if (!enable) begin
          state_d = IDLE;
          gtb_d   = '0;
          idx_d   = '0;
          sched_d = PARK;
          blank_d = 1'b1;
        end else begin
          sched_d = in_range ? tbl_q[idx_q[IDX_W-1:0]] : PARK;
          blank_d = 1'b0;
          if (wrap) begin
            // Unserved entries are simply dropped when the hyperperiod restarts.
            gtb_d        = '0;
            idx_d        = '0;
            cycle_done_d = 1'b1;
            blank_d      = 1'b1;
          end else begin
            gtb_d = gtb_q + 29'd1;
            if (!blank_q && in_range) begin
              if (tx_in) begin
                idx_d   = idx_q + 1'b1;
                blank_d = 1'b1;
              end else if (sched_q != PARK && late) begin
                idx_d   = idx_q + 1'b1;
                miss_d  = 1'b1;
                blank_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gtb_q        <= '0;
      len_q        <= 29'd2;
      idx_q        <= '0;
      cnt_q        <= '0;
      sched_q      <= PARK;
      blank_q      <= 1'b1;
      cycle_done_q <= 1'b0;
      miss_q       <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gtb_q        <= gtb_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      sched_q      <= sched_d;
      blank_q      <= blank_d;
      cycle_done_q <= cycle_done_d;
      miss_q       <= miss_d;
      wr_err_q     <= wr_err_d;
    end
  end

  // Schedule table: writable only while idle, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (state_q == IDLE && wr_en && int'(wr_addr) < DEPTH) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  assign GTB        = {3'b000, gtb_q};
  assign schedule   = sched_q;
  assign index      = idx_q[IDX_W-1:0];
  assign running    = (state_q == RUN);
  assign cycle_done = cycle_done_q;
  assign miss       = miss_q;
  assign wr_err     = wr_err_q;

endmodule
